// File: rtl/divider_if.sv
// divider_if: operand/result handshake between the CPU execute stage and the divider.
interface divider_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        start;
  logic        busy;
  logic        valid;
  logic [31:0] c;
  logic        is_zero;
  logic        is_negative;
  modport master (output a, b, op, start, input busy, valid, c, is_zero, is_negative);
  modport slave  (input a, b, op, start, output busy, valid, c, is_zero, is_negative);
endinterface

// File: rtl/divider.sv
// divider: 32-bit sequential restoring divider, one quotient bit per clock, signed/unsigned quotient or remainder.
module divider (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  s
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t      state, state_nxt;
  logic [1:0]  op_r;
  logic [31:0] dvd, dvs, a_abs, b_abs, q, r;
  logic [32:0] rem, rem_sh, trial;
  logic [4:0]  cnt;
  logic        qsign, rsign, sgn;
  always_comb begin
    state_nxt = state == IDLE ? (s.start ? CALC : IDLE) :
                state == CALC ? (cnt == 5'd0 ? FIX : CALC) : IDLE;
    sgn    = s.op[1];
    a_abs  = (sgn && s.a[31]) ? -s.a : s.a;
    b_abs  = (sgn && s.b[31]) ? -s.b : s.b;
    rem_sh = {rem[31:0], dvd[31]};
    trial  = rem_sh - {1'b0, dvs};
    q      = qsign ? -dvd : dvd;
    r      = rsign ? -rem[31:0] : rem[31:0];
  end
  // Divide-by-zero keeps an all-ones quotient by suppressing the quotient sign.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_r    <= 2'd0;
      dvd     <= 32'd0;
      dvs     <= 32'd0;
      rem     <= 33'd0;
      cnt     <= 5'd0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
      s.busy  <= 1'b0;
      s.valid <= 1'b0;
      s.c     <= 32'd0;
    end else begin
      state   <= state_nxt;
      s.valid <= state == FIX;
      if (state == IDLE && s.start) begin
        op_r   <= s.op;
        dvd    <= a_abs;
        dvs    <= b_abs;
        qsign  <= sgn && (s.a[31] ^ s.b[31]) && (s.b != 32'd0);
        rsign  <= sgn && s.a[31];
        rem    <= 33'd0;
        cnt    <= 5'd31;
        s.busy <= 1'b1;
      end else if (state == CALC) begin
        rem <= trial[32] ? rem_sh : trial;
        dvd <= {dvd[30:0], ~trial[32]};
        cnt <= cnt - 5'd1;
      end else if (state == FIX) begin
        s.c    <= op_r[0] ? r : q;
        s.busy <= 1'b0;
      end
    end
  end
  assign s.is_zero     = s.c == 32'd0;
  assign s.is_negative = s.c[31];
endmodule
